sign_extend: RTL and testbench
==============================

SIGN_EXTEND -- requirements
Module: sign_extend

Interface
REQ-001 The module SHALL have parameter IN_W, default 16, giving the immediate input width.
REQ-002 The module SHALL have parameter OUT_W, default 32, giving the extended output width; OUT_W > IN_W.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-005 The module SHALL have port in_16, input, IN_W bits, the raw immediate field.
REQ-006 The module SHALL have port mode, input, 2 bits, the extension mode select.
REQ-007 The module SHALL have port valid_in, input, 1 bit, which qualifies in_16 and mode this cycle.
REQ-008 The module SHALL have port out_32, output, OUT_W bits, the registered extended result.
REQ-009 The module SHALL have port valid_out, output, 1 bit; high when out_32 holds a result from an accepted input.

Function
REQ-010 mode 2'b00 (SIGN) SHALL produce out_32 = {OUT_W-IN_W copies of in_16[IN_W-1], in_16}.
REQ-011 mode 2'b01 (ZERO) SHALL produce out_32 = {OUT_W-IN_W zeros, in_16}.
REQ-012 mode 2'b10 (UPPER) SHALL produce out_32 = in_16 placed in bits [OUT_W-1:OUT_W-IN_W], lower bits zero.
REQ-013 mode 2'b11 (BRANCH) SHALL produce out_32 = the SIGN result shifted left by 2, bits [1:0] zero, overflow bits discarded.
REQ-014 Latency SHALL be exactly one clock: a sample accepted with valid_in=1 at edge N appears on out_32, with valid_out=1, after edge N.
REQ-015 On a cycle with valid_in=0, out_32 SHALL hold its previous value and valid_out SHALL go to 0 after the edge.
REQ-016 Back-to-back valid inputs SHALL be accepted every cycle, with no stall and no backpressure.
REQ-017 The output SHALL depend only on the sample registered at the last accepted edge, never on the current in_16 or mode.
REQ-018 in_16 values with only bit IN_W-1 set, or with all bits set, SHALL extend correctly with no special casing.

Reset
REQ-019 While rst_n=0, out_32 SHALL be 0 and valid_out SHALL be 0, immediately and independently of clk.
REQ-020 A sample in flight when reset asserts SHALL be discarded; after rst_n deasserts, the first valid output SHALL come from the first input accepted after release.
REQ-021 Reset release SHALL be synchronized by the integrator; the module requires no internal reset synchronizer.

Structure
REQ-022 Mode encodings (SIGN, ZERO, UPPER, BRANCH) SHALL be an enumerated typedef in a shared package, sign_extend_pkg, together with the default width constants.
REQ-023 The pure combinational extension SHALL be one sub-module, sign_extend_core (in_16, mode -> extended value), instantiated once and followed by the output register stage.

Verification
REQ-024 Reset, then SIGN with in_16=16'h0000 -> out_32=32'h00000000 and valid_out=1 one cycle later.
REQ-025 SIGN, walking-one on in_16 bits 0..14 (16'h0001..16'h4000) -> out_32 = 32'h00000001..32'h00004000 respectively.
REQ-026 SIGN, in_16=16'h8000+2^i for i=0..14 (16'h8001..16'hC000) -> out_32 = 32'hFFFF8001..32'hFFFFC000; in_16=16'hFFFF -> 32'hFFFFFFFF.
REQ-027 ZERO with in_16=16'h8000 -> out_32=32'h00008000; UPPER with in_16=16'h1234 -> 32'h12340000; BRANCH with in_16=16'hFFFF -> 32'hFFFFFFFC.
REQ-028 Assert rst_n=0 mid-stream between clock edges -> out_32=0 and valid_out=0 immediately; valid_in=0 for one cycle -> valid_out=0 and out_32 unchanged.

Source files
------------

// File: rtl/sign_extend_pkg.sv
// Shared definitions for the immediate extender: mode encodings and default widths.
package sign_extend_pkg;

  localparam int SE_IN_W  = 16;
  localparam int SE_OUT_W = 32;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_UPPER  = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_e;

endpackage

// File: rtl/sign_extend_core.sv
// Purely combinational immediate extension: selects sign, zero, upper-placement
// or branch-offset (sign extended, word aligned) form of the raw field.
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = SE_IN_W,
  parameter int OUT_W = SE_OUT_W
) (
  input  logic [IN_W-1:0]  in_16,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext_out
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;

  assign w_sign   = {{PAD_W{in_16[IN_W-1]}}, in_16};
  assign w_zero   = {{PAD_W{1'b0}}, in_16};
  assign w_upper  = {in_16, {PAD_W{1'b0}}};
  // Branch offsets are word counts; the two bits shifted out the top are dropped.
  assign w_branch = {w_sign[OUT_W-3:0], 2'b00};

  always_comb begin
    ext_out = w_sign;
    case (ext_mode_e'(mode))
      EXT_SIGN:   ext_out = w_sign;
      EXT_ZERO:   ext_out = w_zero;
      EXT_UPPER:  ext_out = w_upper;
      EXT_BRANCH: ext_out = w_branch;
      default:    ext_out = w_sign;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// Registered immediate extender: one-cycle latency, accepts a sample every cycle,
// holds the last result when idle.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = SE_IN_W,
  parameter int OUT_W = SE_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_16,
  input  logic [1:0]       mode,
  input  logic             valid_in,
  output logic [OUT_W-1:0] out_32,
  output logic             valid_out
);

  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  sign_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_16   (in_16),
    .mode    (mode),
    .ext_out (w_ext)
  );

  // The data register only loads on accepted samples so idle cycles keep the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_out <= w_ext;
      end
    end
  end

  assign out_32    = r_out;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_sign_extend.sv
// Randomized and directed checks of sign_extend against an arithmetic reference model.
module tb_sign_extend;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_16;
  logic [1:0]  mode;
  logic        valid_in;
  logic [31:0] out_32;
  logic        valid_out;

  int          n_cmp;
  int          n_mis;
  int          n_txn;
  logic [31:0] exp_out;
  logic        exp_valid;

  sign_extend #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_16     (in_16),
    .mode      (mode),
    .valid_in  (valid_in),
    .out_32    (out_32),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: treat the field as a signed integer and apply the mode's arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [1:0] m);
    longint u;
    longint s;
    u = longint'(x);
    s = (u >= 32768) ? u - 65536 : u;
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic send(input logic v, input logic [15:0] x, input logic [1:0] m);
    @(negedge clk);
    valid_in = v;
    in_16    = x;
    mode     = m;
    @(posedge clk);
    if (v) exp_out = ref_ext(x, m);
    exp_valid = v;
    #1;
    chk("out", out_32, exp_out);
    chk("vld", {31'b0, valid_out}, {31'b0, exp_valid});
    in_16 = 16'($urandom);
    mode  = 2'($urandom);
    #1;
    chk("hold_after_edge", out_32, exp_out);
    n_txn++;
    $display("txn %0d v=%0b mode=%0d in=%h -> out=%h vld=%0b", n_txn, v, m, x, out_32, valid_out);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; n_txn = 0;
    exp_out = '0; exp_valid = 1'b0;
    rst_n = 1'b0; valid_in = 1'b0; in_16 = '0; mode = '0;
    #1;
    chk("reset_out", out_32, 32'h0);
    chk("reset_vld", {31'b0, valid_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(1'b1, 16'h0000, 2'd0);
    chk("sign_zero", out_32, 32'h0000_0000);
    chk("sign_zero_vld", {31'b0, valid_out}, 32'h1);

    for (int i = 0; i < 15; i++) begin
      send(1'b1, 16'(1 << i), 2'd0);
      chk("walk_pos", out_32, 32'h1 << i);
    end
    for (int i = 0; i < 15; i++) begin
      send(1'b1, 16'h8000 + 16'(1 << i), 2'd0);
      chk("walk_neg", out_32, 32'hFFFF_8000 + (32'h1 << i));
    end
    send(1'b1, 16'hFFFF, 2'd0);
    chk("sign_ones", out_32, 32'hFFFF_FFFF);
    send(1'b1, 16'h8000, 2'd1);
    chk("zero_msb", out_32, 32'h0000_8000);
    send(1'b1, 16'h1234, 2'd2);
    chk("upper", out_32, 32'h1234_0000);
    send(1'b1, 16'hFFFF, 2'd3);
    chk("branch_ones", out_32, 32'hFFFF_FFFC);
    send(1'b1, 16'h7FFF, 2'd3);
    chk("branch_max", out_32, 32'h0001_FFFC);

    // Idle cycle: valid drops, data holds.
    send(1'b0, 16'h5555, 2'd2);
    chk("idle_hold", out_32, 32'h0001_FFFC);

    // Reset asserted between edges with a sample in flight.
    send(1'b1, 16'h7ABC, 2'd0);
    @(negedge clk);
    valid_in = 1'b1; in_16 = 16'h4321; mode = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", out_32, 32'h0);
    chk("midrst_vld", {31'b0, valid_out}, 32'h0);
    exp_out = '0; exp_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_held_out", out_32, 32'h0);
    chk("rst_held_vld", {31'b0, valid_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    chk("discard_out", out_32, 32'h0);
    chk("discard_vld", {31'b0, valid_out}, 32'h0);
    send(1'b0, 16'h1111, 2'd1);
    send(1'b1, 16'h8000, 2'd2);
    chk("first_after_rst", out_32, 32'h8000_0000);

    for (int t = 0; t < 300; t++) begin
      logic [15:0] x;
      case ($urandom_range(0, 5))
        0:       x = 16'h8000;
        1:       x = 16'hFFFF;
        2:       x = 16'h0000;
        3:       x = 16'h7FFF;
        default: x = 16'($urandom);
      endcase
      send($urandom_range(0, 9) < 8, x, 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
